// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular {pc, instr} fetch queue between fetch and decode
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          enq;
  logic          deq;
  logic          wr_en;
  logic          rd_adv;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign in_ready = !full && !flush;
  assign enq      = in_valid && in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !empty || bypass;
  assign deq       = out_valid && out_ready;
  // A bypassed word taken by decode the same cycle never touches storage.
  assign wr_en     = enq && !(bypass && out_ready);
  assign rd_adv    = deq && !bypass;
  assign count     = cnt;

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (!empty) begin
      out_pc    = pc_mem[head];
      out_instr = instr_mem[head];
    end
`else
    if (!empty) begin
      out_pc    = pc_mem[head];
      out_instr = instr_mem[head];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en)
        tail <= tail + 1'b1;
      if (rd_adv)
        head <= head + 1'b1;
      case ({wr_en, rd_adv})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; out_* are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed table-driven bench for fetch_queue
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] ipc;
    logic        ordy;
    logic        eov;
    logic [31:0] epc;
    int          ecnt;
    logic        eir;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'h1234_5013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ir, input logic ordy);
    reset = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ir; out_ready = ordy;
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                     input logic ordy, input logic eov, input logic [31:0] epc,
                     input int ecnt, input logic eir);
    vec_t v;
    v.rst = r; v.fl = f; v.iv = iv; v.ipc = pc; v.ordy = ordy;
    v.eov = eov; v.epc = epc; v.ecnt = ecnt; v.eir = eir;
    vecs.push_back(v);
  endtask

  logic [31:0] model_q[$];
  logic [31:0] exp_pc;
  logic        exp_ov;
  logic [31:0] next_pc;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    // reset, r, f, iv, pc, ordy, eov, epc, ecnt, eir
    add(0,0,0,32'h000,0, 0,32'h000,0,1);
    add(0,0,1,32'h000,0, 0,32'h000,0,1);
    add(0,0,1,32'h004,0, 1,32'h000,1,1);
    add(0,0,1,32'h008,0, 1,32'h000,2,1);
    add(0,0,0,32'h000,1, 1,32'h000,3,1);
    add(0,0,0,32'h000,1, 1,32'h004,2,1);
    add(0,0,0,32'h000,1, 1,32'h008,1,1);
    add(0,0,0,32'h000,1, 0,32'h000,0,1);
    add(0,0,1,32'h100,0, 0,32'h000,0,1);
    add(0,0,1,32'h104,0, 1,32'h100,1,1);
    add(0,0,1,32'h108,0, 1,32'h100,2,1);
    add(0,0,1,32'h10c,0, 1,32'h100,3,1);
    add(0,0,1,32'h110,0, 1,32'h100,4,0);
    add(0,0,0,32'h000,1, 1,32'h100,4,0);
    add(0,0,0,32'h000,0, 1,32'h104,3,1);
    add(0,0,1,32'h114,1, 1,32'h104,3,1);
    add(0,0,0,32'h000,0, 1,32'h108,3,1);
    add(0,1,1,32'h200,0, 1,32'h108,3,0);
    add(0,0,0,32'h000,0, 0,32'h000,0,1);
    add(0,0,1,32'h300,0, 0,32'h000,0,1);
    add(0,0,1,32'h304,1, 1,32'h300,1,1);
    add(0,0,0,32'h000,1, 1,32'h304,1,1);
    add(0,0,0,32'h000,0, 0,32'h000,0,1);
    add(0,0,1,32'h400,0, 0,32'h000,0,1);
    add(0,0,1,32'h404,0, 1,32'h400,1,1);
    add(0,0,1,32'h408,0, 1,32'h400,2,1);
    add(0,0,1,32'h40c,0, 1,32'h400,3,1);
    add(1,0,0,32'h000,0, 1,32'h400,4,0);
    add(0,0,0,32'h000,0, 0,32'h000,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ipc, ins(vecs[i].ipc), vecs[i].ordy);
      exp_ov = vecs[i].eov;
      exp_pc = vecs[i].epc;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (vecs[i].ecnt == 0 && vecs[i].iv && !vecs[i].fl) begin
        exp_ov = 1'b1;
        exp_pc = vecs[i].ipc;
      end
`endif
      #1;
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, exp_ov});
      check($sformatf("v%0d out_pc", i), out_pc, exp_pc);
      check($sformatf("v%0d out_instr", i), out_instr, exp_ov ? ins(exp_pc) : 32'h0);
      check($sformatf("v%0d count", i), {29'b0, count}, vecs[i].ecnt);
      check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].eir});
    end

    // Steady-state streaming at count=2 across several pointer wraps.
    next_pc = 32'h500;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, next_pc, ins(next_pc), 1'b0);
      model_q.push_back(next_pc);
      next_pc += 4;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, next_pc, ins(next_pc), 1'b1);
      #1;
      check($sformatf("wrap%0d count", i), {29'b0, count}, 32'd2);
      check($sformatf("wrap%0d out_pc", i), out_pc, model_q[0]);
      check($sformatf("wrap%0d out_instr", i), out_instr, ins(model_q[0]));
      void'(model_q.pop_front());
      model_q.push_back(next_pc);
      next_pc += 4;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      #1;
      check($sformatf("drain%0d out_pc", i), out_pc, model_q[0]);
      void'(model_q.pop_front());
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("drained out_valid", {31'b0, out_valid}, 32'd0);
    check("drained count", {29'b0, count}, 32'd0);

    // Empty-queue latency: zero with bypass, one cycle without.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h0050_0093, 1'b1);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp out_valid", {31'b0, out_valid}, 32'd1);
    check("byp out_instr", out_instr, 32'h0050_0093);
    check("byp out_pc", out_pc, 32'h10);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("byp count", {29'b0, count}, 32'd0);
    check("byp out_valid after", {31'b0, out_valid}, 32'd0);
`else
    check("lat out_valid same", {31'b0, out_valid}, 32'd0);
    check("lat out_instr same", out_instr, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    check("lat count", {29'b0, count}, 32'd1);
    check("lat out_valid next", {31'b0, out_valid}, 32'd1);
    check("lat out_instr next", out_instr, 32'h0050_0093);
    check("lat out_pc next", out_pc, 32'h10);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("lat count after", {29'b0, count}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, entry count; power of two, at least 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: flush  input  1  discard all queued instructions (branch/jump redirect).
REQ-005 SHALL have port: in_valid  input  1  fetch side presents an instruction.
REQ-006 SHALL have port: in_ready  output  1  queue accepts an instruction this cycle.
REQ-007 SHALL have port: in_pc  input  32  PC of the incoming instruction.
REQ-008 SHALL have port: in_instr  input  32  raw 32-bit RISC-V instruction word.
REQ-009 SHALL have port: out_valid  output  1  head instruction available to decode/ImmGen.
REQ-010 SHALL have port: out_ready  input  1  decode consumes the head this cycle.
REQ-011 SHALL have port: out_pc  output  32  PC of the head instruction.
REQ-012 SHALL have port: out_instr  output  32  head instruction word, fed to decode and immediate generation.
REQ-013 SHALL have port: count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 SHALL store {pc, instr} entries in a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-015 SHALL drive in_ready = (count != DEPTH) && !flush, with no dependence on out_ready.
REQ-016 SHALL enqueue an entry on in_valid && in_ready, at the tail position.
REQ-017 SHALL drive out_valid = (count != 0) in the non-bypass path.
REQ-018 SHALL drive out_pc/out_instr from the head entry, and drive them to 0 when out_valid=0.
REQ-019 SHALL dequeue an entry on out_valid && out_ready, advancing the head.
REQ-020 SHALL preserve strict FIFO order, with no reordering or duplication.
REQ-021 SHALL, on simultaneous enqueue and dequeue, perform both operations and leave count unchanged, including when count==DEPTH-1 and when count==1.
REQ-022 SHALL give flush priority over enqueue and dequeue: the next cycle has count=0 with both pointers at 0, and any same-cycle in_valid entry is dropped.
REQ-023 SHALL, in the non-bypass path, make an enqueued instruction visible at out_* one cycle after acceptance (minimum latency of 1 cycle).
REQ-024 SHALL ignore dequeue attempts when empty and enqueue attempts when full; state is unchanged and count never exceeds DEPTH or underflows.

Reset
REQ-025 SHALL, when reset is asserted at a rising edge, set count=0, head=tail=0, out_valid=0, out_pc=0, out_instr=0 and in_ready=1 from the next cycle.
REQ-026 SHALL give reset priority over flush and all handshakes, and discard contents when reset arrives mid-operation.
REQ-027 SHALL NOT require the storage array to be reset; stale data SHALL never reach out_* while out_valid=0.

Configuration
REQ-028 SHALL implement the macro FETCH_QUEUE_BYPASS_EN so that, when defined and count==0 && in_valid && !flush, out_valid=1 and out_pc/out_instr = in_pc/in_instr combinationally (zero latency).
REQ-029 SHALL, with FETCH_QUEUE_BYPASS_EN defined and a bypassed instruction consumed (out_ready=1), not write that instruction to storage; if out_ready=0, it SHALL be enqueued normally.
REQ-030 SHALL, without FETCH_QUEUE_BYPASS_EN, have no combinational path from in_* to out_*, with behaviour per REQ-017/REQ-023.

Verification
REQ-031 SHALL verify: reset, then enqueue pc=0x0/0x4/0x8 with out_ready=0 -> count=3; then out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8 with matching instrs, then out_valid=0.
REQ-032 SHALL verify: fill 4 entries -> in_ready=0, a 5th in_valid is not accepted and count=4; one dequeue -> in_ready=1 the next cycle.
REQ-033 SHALL verify: count=2 with in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, the output stream is in order, and pointers wrap at least twice.
REQ-034 SHALL verify: count=3 with flush=1 and in_valid=1 together -> next cycle count=0 and out_valid=0; the flushed-cycle instruction never appears at the output.
REQ-035 SHALL verify: reset asserted with count=4 and flush=0 -> next cycle count=0, out_valid=0, out_pc=0, in_ready=1.
REQ-036 SHALL verify: with FETCH_QUEUE_BYPASS_EN, empty queue, in_instr=0x00500093 at pc=0x10 and out_ready=1 -> out_valid=1 with out_instr=0x00500093 in the same cycle and count remains 0; without the macro, out_valid rises one cycle later.
